// File: rtl/dac_spi_tx_pkg.sv
// Shared definitions for the DAC SPI transmitter: frame geometry,
// FSM state encoding and small helpers used by the top and its divider.
package dac_spi_tx_pkg;

  localparam int FRAME_W   = 16;
  localparam int CMD_W     = 4;
  localparam int SAMPLE_W  = 8;
  localparam int PAD_W     = 4;
  localparam int BIT_CNT_W = $clog2(FRAME_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Frame layout on the wire: command nibble, sample byte, zero padding.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [CMD_W-1:0]    cmd,
    input logic [SAMPLE_W-1:0] sample
  );
    return {cmd, sample, {PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dac_spi_tx_clkdiv.sv
// Half-period tick generator for the SPI serial clock. Held at zero while
// disabled so every frame starts with a fresh, phase-aligned half period.
module dac_spi_tx_clkdiv
  import dac_spi_tx_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int               DIV_W    = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = en && (cnt_q == DIV_LAST);

  // Next count: clear when idle, wrap after the last cycle of a half period.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == DIV_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises 8-bit DDS samples into 16-bit mode-0 SPI frames for a serial
// DAC. A one-entry holding register lets the producer hand over the next
// sample while the current frame is still being shifted out.
module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int         CLK_DIV     = 2,
  parameter logic [3:0] CMD         = 4'b0011,
  parameter int         MIN_CS_HIGH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dac_en,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_vld,
  output logic                sample_rdy,
  output logic                dac_cs_n,
  output logic                dac_sclk,
  output logic                dac_din,
  output logic                busy,
  output logic                frame_done
);

  localparam int                   GAP_W    = cnt_width(MIN_CS_HIGH);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(MIN_CS_HIGH - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_W - 1);

  // Holding register
  logic                alive_q;
  logic                alive_d;
  logic                hold_full_q;
  logic                hold_full_d;
  logic [SAMPLE_W-1:0] hold_data_q;
  logic [SAMPLE_W-1:0] hold_data_d;
  logic                accept;
  logic                load;

  // Frame engine
  state_e               state_q;
  state_e               state_d;
  logic [FRAME_W-1:0]   shift_q;
  logic [FRAME_W-1:0]   shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic [GAP_W-1:0]     gap_cnt_d;
  logic                 cs_n_q;
  logic                 cs_n_d;
  logic                 sclk_q;
  logic                 sclk_d;
  logic                 din_q;
  logic                 din_d;
  logic                 frame_done_q;
  logic                 frame_done_d;
  logic [FRAME_W-1:0]   frame_word;
  logic                 div_en;
  logic                 tick;

  // alive_q keeps sample_rdy low while reset is asserted even if dac_en is high.
  assign sample_rdy = dac_en && alive_q && !hold_full_q;
  assign accept     = sample_vld && sample_rdy;
  assign frame_word = build_frame(CMD, hold_data_q);
  assign div_en     = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

  assign dac_cs_n   = cs_n_q;
  assign dac_sclk   = sclk_q;
  assign dac_din    = din_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

  dac_spi_tx_clkdiv #(
    .CLK_DIV (CLK_DIV)
  ) u_clkdiv (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en),
    .tick  (tick)
  );

  // Holding register: fill on handshake, empty on frame load, drop when disabled.
  always_comb begin
    alive_d     = 1'b1;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    if (!dac_en) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = sample_in;
    end else if (load) begin
      hold_full_d = 1'b0;
    end
  end

  // Holding register flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q     <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      alive_q     <= alive_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  // Frame sequencing: chip select, serial clock phases, data shifting, gap timing.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    din_d        = din_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hold_full_q && dac_en) begin
          load      = 1'b1;
          shift_d   = frame_word;
          din_d     = frame_word[FRAME_W-1];
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d  = 1'b0;
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            din_d   = shift_q[FRAME_W-2];
          end else if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_HOLD;
          end else begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          cs_n_d       = 1'b1;
          din_d        = 1'b0;
          frame_done_d = 1'b1;
          gap_cnt_d    = '0;
          state_d      = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame engine flops; every SPI output comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      din_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      din_q        <= din_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
